// File: rtl/if_agc_pkg.sv
// Shared types and helpers for the IF automatic gain controller.
// Optional fast attack on clipping is enabled with IF_AGC_FAST_ATTACK_EN.
package if_agc_pkg;

   localparam int GAIN_W = 3;
   localparam int MAG_W  = 7;

   typedef enum logic [1:0] {
      ST_MANUAL = 2'd0,
      ST_TRACK  = 2'd1,
      ST_HOLD   = 2'd2
   } agc_state_t;

   // -128 has no 7-bit magnitude, so it saturates to full scale.
   function automatic logic [MAG_W-1:0] sat_abs(input logic signed [7:0] x);
      logic [7:0] neg;
      neg = -x;
      if (x == -8'sd128) return 7'd127;
      if (x[7]) return neg[MAG_W-1:0];
      return x[MAG_W-1:0];
   endfunction

endpackage

// File: rtl/if_agc_if.sv
// Sample, control and status bundle between the IF filter / SPI block and the AGC.
interface if_agc_if;
   import if_agc_pkg::*;

   logic signed [7:0]  if_filt_in;
   logic               agc_enable;
   logic [GAIN_W-1:0]  gain_manual;
   logic [GAIN_W-1:0]  gain_sel;
   logic [MAG_W-1:0]   peak_out;
   logic               clip;

   modport master (
      output if_filt_in, agc_enable, gain_manual,
      input  gain_sel, peak_out, clip
   );

   modport slave (
      input  if_filt_in, agc_enable, gain_manual,
      output gain_sel, peak_out, clip
   );

endinterface

// File: rtl/if_agc_peak_det.sv
// Windowed peak detector: magnitude, running maximum, window counter and
// the registered peak of the last completed window.
module if_peak_det
   import if_agc_pkg::*;
#(
   parameter int WIN_LOG2 = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic signed [7:0]   sample,
   output logic [MAG_W-1:0]    mag,
   output logic                window_end,
   output logic [MAG_W-1:0]    win_peak,
   output logic [MAG_W-1:0]    peak
);

   logic [WIN_LOG2-1:0] cnt;
   logic [MAG_W-1:0]    acc;

   assign mag        = sat_abs(sample);
   assign window_end = &cnt;
   assign win_peak   = (mag > acc) ? mag : acc;

   // A clear restarts the window without evaluating it.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         acc  <= '0;
         peak <= '0;
      end else begin
         if (window_end) peak <= win_peak;
         if (clear || window_end) begin
            cnt <= '0;
            acc <= '0;
         end else begin
            cnt <= cnt + WIN_LOG2'(1);
            acc <= win_peak;
         end
      end
   end

endmodule

// File: rtl/if_agc.sv
// Automatic gain controller for the 455 kHz IF filter, with manual passthrough.
// Define IF_AGC_FAST_ATTACK_EN to cut gain immediately on a clipped sample.
module if_agc
   import if_agc_pkg::*;
#(
   parameter int WIN_LOG2      = 10,
   parameter int HI_THRESH     = 96,
   parameter int LO_THRESH     = 32,
   parameter int DECAY_WINDOWS = 4,
   parameter int GAIN_MAX      = 5,
   parameter int GAIN_INIT     = 0
) (
   input logic         clk,
   input logic         RST,
   if_agc_if.slave     bus
);

   localparam int LOW_W = $clog2(DECAY_WINDOWS + 1);
   localparam logic [GAIN_W-1:0] G_MAX  = GAIN_W'(GAIN_MAX);
   localparam logic [GAIN_W-1:0] G_INIT = GAIN_W'(GAIN_INIT);
   localparam logic [MAG_W-1:0]  HI     = MAG_W'(HI_THRESH);
   localparam logic [MAG_W-1:0]  LO     = MAG_W'(LO_THRESH);
   localparam logic [LOW_W-1:0]  DECAY  = LOW_W'(DECAY_WINDOWS);

   agc_state_t         state_q, state_d;
   logic [GAIN_W-1:0]  gain_q, gain_d, gain_dec, gain_inc, manual_sat;
   logic [LOW_W-1:0]   low_q, low_d, low_inc;
   logic               clip_q, clear, fast_hit;
   logic [MAG_W-1:0]   mag, win_peak, peak;
   logic               window_end;

   if_peak_det #(.WIN_LOG2(WIN_LOG2)) u_peak (
      .clk        (clk),
      .rst        (RST),
      .clear      (clear),
      .sample     (bus.if_filt_in),
      .mag        (mag),
      .window_end (window_end),
      .win_peak   (win_peak),
      .peak       (peak)
   );

   assign manual_sat = (bus.gain_manual > G_MAX) ? G_MAX : bus.gain_manual;
   assign gain_dec   = (gain_q == '0) ? '0 : gain_q - GAIN_W'(1);
   assign gain_inc   = (gain_q >= G_MAX) ? G_MAX : gain_q + GAIN_W'(1);
   assign low_inc    = low_q + LOW_W'(1);

`ifdef IF_AGC_FAST_ATTACK_EN
   assign fast_hit = (mag == '1);
`else
   assign fast_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q <= ST_MANUAL;
         gain_q  <= G_INIT;
         low_q   <= '0;
         clip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gain_q  <= gain_d;
         low_q   <= low_d;
         clip_q  <= (mag == '1);
      end
   end

   // Dropping agc_enable overrides any window event in the same cycle.
   always_comb begin
      state_d = state_q;
      gain_d  = gain_q;
      low_d   = low_q;
      clear   = 1'b0;
      if (!bus.agc_enable) begin
         state_d = ST_MANUAL;
         if (state_q == ST_MANUAL) gain_d = manual_sat;
      end else begin
         case (state_q)
            ST_MANUAL: begin
               state_d = ST_HOLD;
               low_d   = '0;
               clear   = 1'b1;
            end
            ST_HOLD: begin
               if (window_end) state_d = ST_TRACK;
            end
            ST_TRACK: begin
               if (fast_hit) begin
                  gain_d  = gain_dec;
                  low_d   = '0;
                  clear   = 1'b1;
                  state_d = ST_HOLD;
               end else if (window_end) begin
                  if (win_peak >= HI) begin
                     gain_d  = gain_dec;
                     low_d   = '0;
                     state_d = ST_HOLD;
                  end else if (win_peak < LO) begin
                     if (low_inc == DECAY) begin
                        low_d = '0;
                        if (gain_q < G_MAX) begin
                           gain_d  = gain_inc;
                           state_d = ST_HOLD;
                        end
                     end else begin
                        low_d = low_inc;
                     end
                  end else begin
                     low_d = '0;
                  end
               end
            end
            default: state_d = ST_MANUAL;
         endcase
      end
   end

   assign bus.gain_sel = gain_q;
   assign bus.peak_out = peak;
   assign bus.clip     = clip_q;

endmodule

// File: doc/if_agc.md
Name: if_agc

Overview:
- Automatic gain controller closing the loop around the 455 kHz IF filter.
- Consumes the filter's signed 8-bit output (`if_filt_out`) and drives the filter's 3-bit gain select (`gain_spi`).
- Per-window peak detection with attack/decay steps; manual passthrough when AGC is disabled.
- Sits between the IF filter and the SPI control registers in the receiver datapath.

Parameters:
- WIN_LOG2, 10: window length is 2^WIN_LOG2 clk cycles.
- HI_THRESH, 96: window peak >= this value causes a gain decrement (attack).
- LO_THRESH, 32: window peak < this value counts toward a gain increment (decay).
- DECAY_WINDOWS, 4: consecutive low windows required before an increment.
- GAIN_MAX, 5: highest usable gain code (code 5 and above select the filter's least-significant slice).
- GAIN_INIT, 0: gain code loaded at reset (lowest gain).

Ports:
- clk  in  1  system clock; one IF sample per cycle.
- RST  in  1  synchronous reset, active-high.
- if_filt_in  in  8  signed filtered IF sample.
- agc_enable  in  1  1 = automatic control, 0 = manual.
- gain_manual  in  3  manual gain code, from SPI.
- gain_sel  out  3  gain code to the IF filter `gain_spi` input; registered.
- peak_out  out  7  peak magnitude of the last completed window; registered.
- clip  out  1  one-cycle pulse when |sample| >= 127.

Behaviour:
- Reset (RST=1 at a clk edge):
  - gain_sel=GAIN_INIT, peak_out=0, clip=0.
  - Window counter=0, peak accumulator=0, low-window counter=0, state=ST_MANUAL.
- Magnitude:
  - mag = |if_filt_in|, with -128 saturating to 127; 7-bit unsigned.
  - clip is registered: it asserts the cycle after a sample with mag=127.
- Peak accumulator: acc <= max(acc, mag) every cycle.
- Window end is the cycle where the counter equals 2^WIN_LOG2-1. On that cycle:
  - peak_out <= max(acc, mag).
  - acc is cleared.
  - The counter wraps to 0.
- States:
  - ST_MANUAL
    - gain_sel <= min(gain_manual, GAIN_MAX) every cycle.
    - agc_enable=1 → ST_HOLD; counter, acc and low-window counter are cleared and gain_sel is kept.
  - ST_TRACK, evaluated at window end with p = final window peak:
    - p >= HI_THRESH: gain_sel decrements (floor 0), low-window counter clears, → ST_HOLD.
    - p < LO_THRESH: low-window counter increments. When it reaches DECAY_WINDOWS, gain_sel increments (ceiling GAIN_MAX), the counter clears, → ST_HOLD.
    - Otherwise: low-window counter clears.
  - ST_HOLD
    - Discards the peak of one full window so the IIR can settle, then → ST_TRACK.
    - gain_sel is unchanged during HOLD.
  - agc_enable=0 in any state → ST_MANUAL on the next edge; this takes priority over all window events.
- Latency: a gain change is visible on gain_sel one cycle after the window-end cycle.
- Saturation:
  - Decrement at 0 still enters HOLD.
  - Increment at GAIN_MAX leaves gain unchanged, clears the low-window counter, and stays in TRACK.
- Mid-window reset: all counters restart; there is no partial-window evaluation.

Optional Feature:
- Macro: IF_AGC_FAST_ATTACK_EN.
- Defined:
  - In ST_TRACK, a clip (mag=127) decrements gain_sel on the next edge (floor 0).
  - The window counter and acc are cleared and the state goes → ST_HOLD.
  - If a clip coincides with window end, only a single decrement occurs.
- Undefined: clip only drives the clip output; attack happens at window end only.

Decomposition:
- Package if_agc_pkg holds:
  - state encoding (ST_MANUAL, ST_TRACK, ST_HOLD, 2 bits);
  - GAIN_W=3, MAG_W=7;
  - the saturating-abs function.
- One natural sub-module: if_peak_det, covering abs, the peak accumulator, the window counter, and the window_end / peak outputs.

Test Plan (WIN_LOG2=4, 16-cycle windows):
- Reset, then agc_enable=0, gain_manual=7 → gain_sel=5 one cycle later; gain_manual=3 → gain_sel=3.
- AGC on from gain 3, constant input 100 → after HOLD window, gain_sel=2 one cycle after the next window end, then 1, 0, and stays 0.
- AGC on from gain 2, constant input 10 → increment to 3 only after 4 consecutive low windows (64 cycles post-HOLD); a single sample of 50 inside the run resets the count.
- Input -128 for one cycle → clip=1 for exactly one cycle and peak_out=127 at window end. With IF_AGC_FAST_ATTACK_EN, gain_sel drops by one the next cycle; without it, the drop waits for window end.
- Pulse RST mid-window with gain at 4 → gain_sel=0, peak_out=0, state MANUAL, no stale window evaluation.
- agc_enable dropped on a window-end cycle with peak 120 → gain_sel follows gain_manual; no decrement is applied.
